row_scan_ctrl: RTL and testbench
================================

Name: row_scan_ctrl

Overview:
- Sequential controller that sits directly upstream of the team's 3-to-8 decoder.
- Steps a row index through the enabled rows of an 8-row bank and drives the decoder's select and enable inputs.
- Holds each row for a programmable dwell time. Inserts a blanking gap with enable low between rows to prevent ghosting.
- Reports frame completion to the system controller.

Parameters:
- N_ROWS, 8, number of rows; legal range 2..16. SEL_W = $clog2(N_ROWS).
- DWELL, 4, cycles en is held high per row; must be >= 1.
- BLANK, 1, cycles en is held low between consecutive rows; 0 is legal.

Ports:
- clk  input  1  rising-edge clock (single clock domain).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one frame scan; sampled only in IDLE.
- stop  input  1  abort scan; wins over start.
- row_mask  input  N_ROWS  bit i=1 means row i is scanned. Sampled at start and at each row boundary.
- sel  output  SEL_W  row index to decoder (registered).
- en  output  1  decoder enable (registered).
- busy  output  1  high from the first DWELL cycle through the last.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, en=0, busy=0, frame_done=0, counter=0. Outputs update immediately, not on a clock edge.
- States: IDLE, DWELL, BLANK. All outputs are registered, so there is no combinational path from inputs to outputs.
- IDLE, start=1, row_mask!=0:
  - Next cycle: sel=lowest set bit index, en=1, busy=1, state DWELL.
  - Dwell counter loads DWELL-1.
- IDLE, start=1, row_mask==0: next cycle frame_done=1 for one cycle; en and busy stay 0; remain IDLE.
- DWELL: en=1 for exactly DWELL consecutive cycles per row. Counter decrements; the row boundary is the cycle the counter reads 0. At the boundary:
  - Next row exists (set bit in row_mask above sel) and BLANK>0: en=0, sel holds, state BLANK for exactly BLANK cycles. Then sel=next row, en=1, state DWELL.
  - Next row exists and BLANK==0: sel=next row the following cycle, en stays 1 with no gap.
  - No higher set bit: en=0, busy=0, frame_done=1 for one cycle, state IDLE, sel holds the last row.
- stop=1 in any state: next cycle en=0, busy=0, state IDLE, no frame_done; sel holds. stop has priority over a simultaneous start.
- start while busy: ignored.
- row_mask changes mid-frame: take effect only at the next row boundary. Rows at or below the current sel are never revisited within a frame.
- Row order is strictly ascending; no wrap-around within a frame, except under the optional feature.
- Reset mid-frame: immediate return to reset values. No frame_done.
- Cycle counts per frame:
  - en-high cycles = DWELL × popcount(mask).
  - Total cycles from start to frame_done = 1 + DWELL×k + BLANK×(k−1), where k = popcount(mask).

Optional Feature:
- Macro: ROW_SCAN_CONT_EN.
- Defined: continuous mode. At the end of a frame, frame_done still pulses one cycle, but busy stays 1.
  - Controller enters BLANK (when BLANK>0), then wraps sel to the lowest set bit of the current row_mask and continues.
  - If row_mask==0 at the wrap point: go IDLE, busy=0.
  - Only stop or reset ends scanning.
- Undefined: single-frame behaviour exactly as above; no continuous-mode logic is synthesised.

Decomposition:
- Package row_scan_pkg:
  - state enum typedef (IDLE, DWELL, BLANK).
  - Default N_ROWS/DWELL/BLANK localparams.
  - SEL_W function.
- Sub-module row_next_find: combinational. Inputs mask and current index plus a "from_start" flag. Outputs found flag and next set-bit index (lowest above current, or lowest overall when from_start=1). Reused for first-row and next-row lookup.
- Dwell/blank counter stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-DWELL -> sel=0, en=0, busy=0, frame_done=0 immediately, without waiting for a clock edge.
- Defaults, mask=8'b1000_0101, start pulse:
  - sel=0 en=1 for 4 cycles, en=0 1 cycle.
  - sel=2 en=1 4 cycles, en=0 1 cycle.
  - sel=7 en=1 4 cycles.
  - Then frame_done=1 for one cycle, busy=0; total cycles from start to frame_done = 15.
- mask=0, start -> frame_done pulse next cycle; en never 1, busy never 1.
- BLANK=0, mask=8'hFF -> sel increments 0..7 every 4 cycles with en continuously 1 for 32 cycles.
- stop asserted on the 2nd DWELL cycle of sel=2 (same cycle as start re-pulse) -> next cycle en=0, busy=0, no frame_done; the start is ignored.
- ROW_SCAN_CONT_EN, mask=8'b0001_0010 -> sel sequence 1,4,1,4,… with frame_done pulsing once per pass; stop ends scanning.

Source files
------------

// File: rtl/row_scan_pkg.sv
// Shared types, default sizing and helpers for the row scan controller.
package row_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DWELL = 2'b01,
        S_BLANK = 2'b10
    } state_e;

    localparam int N_ROWS_DEF = 8;
    localparam int DWELL_DEF  = 4;
    localparam int BLANK_DEF  = 1;

    // Width of a row index for a bank of n rows (at least one bit).
    function automatic int sel_w(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/row_next_find.sv
// Combinational search for the next enabled row: the lowest set mask bit
// strictly above cur, or the lowest set bit overall when from_start is high.
module row_next_find #(
    parameter int N_ROWS = 8,
    parameter int SEL_W  = 3
) (
    input  logic [N_ROWS-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_start,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    // Scan from the top down so the last hit written is the lowest eligible row.
    always_comb begin
        found = 1'b0;
        idx   = {SEL_W{1'b0}};
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/row_scan_ctrl.sv
// Row scan controller feeding the 3-to-8 decoder: steps through enabled rows
// in ascending order, holds each for DWELL cycles with a BLANK-cycle enable-low
// gap between rows, and pulses frame_done at the end of a frame.
// Optional build macro ROW_SCAN_CONT_EN: continuous scanning, wrapping back to
// the lowest enabled row after each frame until stop or reset.
module row_scan_ctrl
    import row_scan_pkg::*;
#(
    parameter int N_ROWS = N_ROWS_DEF,
    parameter int DWELL  = DWELL_DEF,
    parameter int BLANK  = BLANK_DEF,
    parameter int SEL_W  = sel_w(N_ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [N_ROWS-1:0] row_mask,
    output logic [SEL_W-1:0]  sel,
    output logic              en,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   next_q, next_d;   // row to enter when the blanking gap ends
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               fd_q, fd_d;
    logic               nf_found;
    logic [SEL_W-1:0]   nf_idx;

    // From IDLE the finder returns the first row; otherwise the row above sel.
    row_next_find #(.N_ROWS(N_ROWS), .SEL_W(SEL_W)) u_next (
        .mask       (row_mask),
        .cur        (sel_q),
        .from_start (state_q == S_IDLE),
        .found      (nf_found),
        .idx        (nf_idx)
    );

`ifdef ROW_SCAN_CONT_EN
    logic               wrap_q, wrap_d;   // blanking gap ends with a wrap to the first row
    logic               ff_found;
    logic [SEL_W-1:0]   ff_idx;

    // Wrap-point lookup: lowest enabled row of the current mask.
    row_next_find #(.N_ROWS(N_ROWS), .SEL_W(SEL_W)) u_first (
        .mask       (row_mask),
        .cur        (sel_q),
        .from_start (1'b1),
        .found      (ff_found),
        .idx        (ff_idx)
    );
`endif

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        next_d  = next_q;
        en_d    = en_q;
        busy_d  = busy_q;
        fd_d    = 1'b0;
`ifdef ROW_SCAN_CONT_EN
        wrap_d  = wrap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && nf_found) begin
                    state_d = S_DWELL;
                    sel_d   = nf_idx;
                    cnt_d   = DWELL_LOAD;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (start) begin
                    fd_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DWELL: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (nf_found) begin
                    if (BLANK > 0) begin
                        state_d = S_BLANK;
                        next_d  = nf_idx;
                        cnt_d   = BLANK_LOAD;
                        en_d    = 1'b0;
                    end else begin
                        sel_d = nf_idx;
                        cnt_d = DWELL_LOAD;
                    end
                end else begin
                    fd_d = 1'b1;
`ifdef ROW_SCAN_CONT_EN
                    if (BLANK > 0) begin
                        state_d = S_BLANK;
                        wrap_d  = 1'b1;
                        cnt_d   = BLANK_LOAD;
                        en_d    = 1'b0;
                    end else if (ff_found) begin
                        sel_d = ff_idx;
                        cnt_d = DWELL_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
`endif
                end
            end
            S_BLANK: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
`ifdef ROW_SCAN_CONT_EN
                end else if (wrap_q) begin
                    wrap_d = 1'b0;
                    if (ff_found) begin
                        state_d = S_DWELL;
                        sel_d   = ff_idx;
                        cnt_d   = DWELL_LOAD;
                        en_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
`endif
                end else begin
                    state_d = S_DWELL;
                    sel_d   = next_q;
                    cnt_d   = DWELL_LOAD;
                    en_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            sel_d   = sel_q;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            fd_d    = 1'b0;
`ifdef ROW_SCAN_CONT_EN
            wrap_d  = 1'b0;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            sel_q   <= {SEL_W{1'b0}};
            next_q  <= {SEL_W{1'b0}};
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
`ifdef ROW_SCAN_CONT_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            next_q  <= next_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
`ifdef ROW_SCAN_CONT_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Bench for row_scan_ctrl: directed vector table, BLANK=0 instance,
// asynchronous reset, and randomized traffic against a slot-timing model.
module tb_row_scan_ctrl;

    localparam int DW = 4;
    localparam int BL = 1;
`ifdef ROW_SCAN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [2:0] sel;
    logic       en, busy, fd;
    logic       start_b = 1'b0, stop_b = 1'b0;
    logic [7:0] mask_b = 8'h00;
    logic [2:0] sel_b;
    logic       en_b, busy_b, fd_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    row_scan_ctrl #(.N_ROWS(8), .DWELL(DW), .BLANK(BL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .row_mask(mask),
        .sel(sel), .en(en), .busy(busy), .frame_done(fd)
    );

    row_scan_ctrl #(.N_ROWS(8), .DWELL(DW), .BLANK(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .row_mask(mask_b),
        .sel(sel_b), .en(en_b), .busy(busy_b), .frame_done(fd_b)
    );

    typedef struct {
        int st; int sp; int mk;
        int sel; int en; int busy; int fd;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int st, input int sp, input int mk,
                                input int s, input int e, input int b, input int f);
        vec_t v;
        v.st = st; v.sp = sp; v.mk = mk; v.sel = s; v.en = e; v.busy = b; v.fd = f;
        vq.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    // A row occupies a slot of DW enabled cycles followed by BL blank cycles;
    // m_t is the position inside the slot of the cycle being presented.
    bit m_active, m_en, m_busy, m_fd;
    int m_row, m_t, m_pend;

    function automatic int lowest_above(input logic [7:0] m, input int cur);
        for (int i = 0; i < 8; i++) begin
            if (m[i] && i > cur) return i;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        m_active = 0; m_en = 0; m_busy = 0; m_fd = 0; m_row = 0; m_t = 0; m_pend = 0;
    endfunction

    function automatic void m_enter(input int r);
        if (r < 0) begin
            m_active = 0; m_en = 0; m_busy = 0;
        end else begin
            m_row = r; m_t = 0; m_en = 1;
        end
    endfunction

    function automatic void model_step(input bit st, input bit sp, input logic [7:0] m);
        int r;
        m_fd = 0;
        if (sp) begin
            m_active = 0; m_en = 0; m_busy = 0;
        end else if (!m_active) begin
            if (st) begin
                r = lowest_above(m, -1);
                if (r >= 0) begin
                    m_active = 1; m_busy = 1; m_enter(r);
                end else begin
                    m_fd = 1;
                end
            end
        end else if (m_t < DW - 1) begin
            m_t++;
        end else if (m_t == DW - 1) begin
            r = lowest_above(m, m_row);
            if (r < 0) begin
                m_fd = 1;
                if (CONT && BL > 0) begin
                    m_pend = -2; m_t = DW; m_en = 0;
                end else if (CONT) begin
                    m_enter(lowest_above(m, -1));
                end else begin
                    m_active = 0; m_en = 0; m_busy = 0;
                end
            end else if (BL == 0) begin
                m_enter(r);
            end else begin
                m_pend = r; m_t = DW; m_en = 0;
            end
        end else if (m_t + 1 == DW + BL) begin
            m_enter((m_pend == -2) ? lowest_above(m, -1) : m_pend);
        end else begin
            m_t++;
        end
    endfunction

    initial begin
        // reset values while rst_n is held low
        #3;
        check("reset.sel", int'(sel), 0);
        check("reset.en", int'(en), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.frame_done", int'(fd), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

`ifndef ROW_SCAN_CONT_EN
        // full frame on mask 1000_0101: rows 0,2,7, start to frame_done = 15 cycles
        add(1,0,8'h85, 0,1,1,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h85, 0,1,1,0);
        add(0,0,8'h85, 0,0,1,0);
        for (int i = 0; i < 4; i++) add(0,0,8'h85, 2,1,1,0);
        add(0,0,8'h85, 2,0,1,0);
        for (int i = 0; i < 4; i++) add(0,0,8'h85, 7,1,1,0);
        add(0,0,8'h85, 7,0,0,1);
        add(0,0,8'h85, 7,0,0,0);
        // stop with a start re-pulse on the 2nd dwell cycle of row 2
        add(1,0,8'h85, 0,1,1,0);
        for (int i = 0; i < 3; i++) add(0,0,8'h85, 0,1,1,0);
        add(0,0,8'h85, 0,0,1,0);
        add(0,0,8'h85, 2,1,1,0);
        add(0,0,8'h85, 2,1,1,0);
        add(1,1,8'h85, 2,0,0,0);
        add(0,0,8'h85, 2,0,0,0);
        // empty mask: immediate frame_done; stop beats a start in IDLE
        add(1,0,8'h00, 2,0,0,1);
        add(0,0,8'h00, 2,0,0,0);
        add(1,1,8'h85, 2,0,0,0);
        // mask change mid-row (row 2 dropped, row 7 added, row 0 never revisited); start while busy ignored
        add(1,0,8'h06, 1,1,1,0);
        add(1,0,8'h81, 1,1,1,0);
        add(0,0,8'h81, 1,1,1,0);
        add(0,0,8'h81, 1,1,1,0);
        add(0,0,8'h81, 1,0,1,0);
        for (int i = 0; i < 4; i++) add(0,0,8'h81, 7,1,1,0);
        add(0,0,8'h81, 7,0,0,1);
        add(0,0,8'h81, 7,0,0,0);
        foreach (vq[i]) begin
            start = vq[i].st[0]; stop = vq[i].sp[0]; mask = vq[i].mk[7:0];
            step();
            check($sformatf("vec%0d.sel", i), int'(sel), vq[i].sel);
            check($sformatf("vec%0d.en", i), int'(en), vq[i].en);
            check($sformatf("vec%0d.busy", i), int'(busy), vq[i].busy);
            check($sformatf("vec%0d.frame_done", i), int'(fd), vq[i].fd);
        end
        start = 1'b0; stop = 1'b0;
`else
        // continuous mode on mask 0001_0010: rows 1,4,1,4,... one frame_done per pass
        mask = 8'h12; start = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < DW; c++) begin
                check($sformatf("cont%0d.r1.sel", p), int'(sel), 1);
                check($sformatf("cont%0d.r1.en", p), int'(en), 1);
                step();
            end
            check($sformatf("cont%0d.gap.en", p), int'(en), 0);
            step();
            for (int c = 0; c < DW; c++) begin
                check($sformatf("cont%0d.r4.sel", p), int'(sel), 4);
                check($sformatf("cont%0d.r4.fd", p), int'(fd), 0);
                step();
            end
            check($sformatf("cont%0d.wrap.fd", p), int'(fd), 1);
            check($sformatf("cont%0d.wrap.busy", p), int'(busy), 1);
            check($sformatf("cont%0d.wrap.en", p), int'(en), 0);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("cont.stop.en", int'(en), 0);
        check("cont.stop.busy", int'(busy), 0);
        check("cont.stop.fd", int'(fd), 0);
`endif

        // BLANK=0 instance, all rows: sel steps every DW cycles, en never drops
        mask_b = 8'hFF; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 8 * DW; i++) begin
            check($sformatf("b0.%0d.sel", i), int'(sel_b), i / DW);
            check($sformatf("b0.%0d.en", i), int'(en_b), 1);
            step();
        end
        check("b0.end.frame_done", int'(fd_b), 1);
        stop_b = 1'b1;
        step();
        stop_b = 1'b0;
        check("b0.stop.en", int'(en_b), 0);

        // asynchronous reset mid-dwell on row 2, checked between clock edges
        mask = 8'h85; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre_reset.sel", int'(sel), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset.sel", int'(sel), 0);
        check("async_reset.en", int'(en), 0);
        check("async_reset.busy", int'(busy), 0);
        check("async_reset.frame_done", int'(fd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset.frame_done", int'(fd), 0);
        m_reset();

        // randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) begin
                mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            end
            step();
            model_step(start, stop, mask);
            check($sformatf("rnd%0d.sel", cyc), int'(sel), m_row);
            check($sformatf("rnd%0d.en", cyc), int'(en), int'(m_en));
            check($sformatf("rnd%0d.busy", cyc), int'(busy), int'(m_busy));
            check($sformatf("rnd%0d.frame_done", cyc), int'(fd), int'(m_fd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
